// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request channel, redirect from
// execute, and the decode-side instruction stream.
//   master : the fetch unit (drives imem_req/imem_addr and the inst_* stream)
//   slave  : the environment (memory, execute, decode)
interface fetch_queue_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_ready, imem_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_ready, imem_data, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with a prefetch FIFO.
// Owns the PC, issues word reads to instruction memory (same-cycle response on
// imem_ready), buffers {pc, instruction} pairs and hands them to decode with a
// valid/ready handshake. A redirect flushes the queue and restarts fetch.
// Ports:
//   CLK, Reset : clock, synchronous active-high reset
//   startPC    : fetch PC loaded on reset
//   bus        : fetch_queue_unit_if.master (imem_*, redirect*, inst_*)
// Optional feature (macro FETCH_PERF_EN): saturating counters perf_fetched,
// perf_flushes and perf_stall_cycles.
module fetch_queue_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [31:0]               startPC,
    fetch_queue_unit_if.master        bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [15:0]               perf_flushes,
    output logic [31:0]               perf_stall_cycles
`endif
);

    typedef enum logic [0:0] {StFetch, StStall} state_e;

    localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      buf_data_q [DEPTH];
    logic [31:0]      buf_pc_q   [DEPTH];
    logic             push, pop;

    assign bus.imem_req   = (state_q == StFetch) && (count_q < CntFull) && !Reset;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0) && !Reset;
    // Head is forced to zero when empty so reset shows clean outputs.
    assign bus.inst_data  = bus.inst_valid ? buf_data_q[rd_ptr_q] : '0;
    assign bus.inst_pc    = bus.inst_valid ? buf_pc_q[rd_ptr_q]   : '0;

    // A redirect discards both the same-cycle response and the same-cycle pop.
    assign push = bus.imem_req && bus.imem_ready && !bus.redirect;
    assign pop  = bus.inst_valid && bus.inst_ready && !bus.redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            state_d    = StFetch;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            unique case (state_q)
                StFetch: if (push && !pop && count_q == CntFull - 1'b1) state_d = StStall;
                StStall: if (pop) state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= StFetch;
            fetch_pc_q <= {startPC[31:2], 2'b00};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= bus.imem_data;
            buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [15:0] perf_flushes_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && perf_fetched_q != '1) perf_fetched_q <= perf_fetched_q + 1'b1;
            if (bus.redirect && perf_flushes_q != '1) perf_flushes_q <= perf_flushes_q + 1'b1;
            if (state_q == StStall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_flushes      = perf_flushes_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] B = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] startPC;
    int          checks = 0;
    int          errors = 0;

    fetch_queue_unit_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushes;
    logic [31:0] perf_stall_cycles;
`endif

    fetch_queue_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .startPC          (startPC),
        .bus              (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_flushes     (perf_flushes),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: the queue contents and the next PC to fetch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc = 32'h0;

    typedef struct {
        logic        rst, rdy, ird, rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic rdy, input logic ird, input logic rd,
                         input logic [31:0] rpc);
        @(negedge CLK);
        Reset           = r;
        bus.imem_ready  = rdy;
        bus.inst_ready  = ird;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_data   = $urandom;
        #1;
    endtask

    // Advance one clock and update the model from the rules of the stage.
    task automatic tick();
        logic        mreq, mval, psh, pp, r, rd;
        logic [31:0] rpc;
        ent_t        e;
        mreq  = !Reset && (m_q.size() < DEPTH);
        mval  = !Reset && (m_q.size() > 0);
        psh   = mreq && bus.imem_ready && !bus.redirect;
        pp    = mval && bus.inst_ready && !bus.redirect;
        e.pc   = m_pc;
        e.data = bus.imem_data;
        r     = Reset;
        rd    = bus.redirect;
        rpc   = bus.redirect_pc;
        @(posedge CLK);
        if (r) begin
            m_q.delete();
            m_pc = startPC;
        end else if (rd) begin
            m_q.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            if (pp) void'(m_q.pop_front());
            if (psh) begin
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        logic mreq, mval;
        mreq = !Reset && (m_q.size() < DEPTH);
        mval = !Reset && (m_q.size() > 0);
        chk("rnd_req", {31'b0, bus.imem_req}, {31'b0, mreq});
        if (mreq) chk("rnd_addr", bus.imem_addr, m_pc);
        chk("rnd_valid", {31'b0, bus.inst_valid}, {31'b0, mval});
        if (mval) begin
            chk("rnd_pc", bus.inst_pc, m_q[0].pc);
            chk("rnd_data", bus.inst_data, m_q[0].data);
        end
    endtask

    initial begin
        // rst rdy ird rd rpc | req addr valid pc
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, B,         1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, B + 4,     1'b1, B};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, B + 8,     1'b1, B};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, B + 12,    1'b1, B};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, B};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, B};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, B + 16,    1'b1, B + 4};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, B + 4};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, B + 'h103, 1'b1, B + 20,    1'b1, B + 8};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, B + 'h100, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, B + 'h104, 1'b1, B + 'h100};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B + 'h108, 1'b1, B + 'h104};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,     1'b1, B + 'h108, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, B + 'h108, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, B + 'h10c, 1'b1, B + 'h108};

        startPC         = B;
        Reset           = 1'b1;
        bus.imem_ready  = 1'b0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_data   = 32'h0;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // Directed table: fill to full, stall, pop, redirect, memory wait states.
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].rst, tbl[i].rdy, tbl[i].ird, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("tbl%0d_req", i), {31'b0, bus.imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, bus.inst_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid || tbl[i].rst)
                chk($sformatf("tbl%0d_pc", i), bus.inst_pc, tbl[i].e_pc);
            if (tbl[i].rst) chk($sformatf("tbl%0d_data", i), bus.inst_data, 32'h0);
            tick();
        end

        // Reset with a full queue and a simultaneous redirect.
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
        end
        apply(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1000);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("rst_pc", bus.inst_pc, 32'h0);
        chk("rst_data", bus.inst_data, 32'h0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_restart_req", {31'b0, bus.imem_req}, 32'h1);
        chk("rst_restart_addr", bus.imem_addr, B);
        chk("rst_restart_valid", {31'b0, bus.inst_valid}, 32'h0);
        tick();

        // Back-to-back redirects (latest wins) and PC wrap at the top of memory.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3000);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        chk("b2b_addr", bus.imem_addr, 32'h0000_3000);
        chk("b2b_valid", {31'b0, bus.inst_valid}, 32'h0);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
        chk("wrap_valid0", {31'b0, bus.inst_valid}, 32'h0);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc1", bus.inst_pc, 32'hFFFF_FFF8);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr2", bus.imem_addr, 32'h0000_0000);
        chk("wrap_pc2", bus.inst_pc, 32'hFFFF_FFFC);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr3", bus.imem_addr, 32'h0000_0004);
        chk("wrap_pc3", bus.inst_pc, 32'h0000_0000);
        tick();

`ifdef FETCH_PERF_EN
        // 10 fetches, 2 redirects, 3 stall cycles.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_8000);
        tick();
        apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_9000);
        tick();
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_flushes", {16'b0, perf_flushes}, 32'd2);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
        tick();
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            logic        r, rdy, ird, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(99) == 0);
            rdy = ($urandom_range(9) < 7);
            ird = ($urandom_range(9) < 6);
            rd  = ($urandom_range(19) == 0);
            rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom;
            if (r) startPC = $urandom & ~32'h3;
            apply(r, rdy, ird, rd, rpc);
            check_model();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
